// File: rtl/ring_counter.sv
// ring_counter: one-hot ring sequencer. A single set bit rotates left one
// position per clock; any non-one-hot value is replaced by INIT on the next
// edge, so the ring can never stay stuck in an illegal pattern.
module ring_counter #(
    parameter int            N    = 4,
    parameter logic [N-1:0]  INIT = {{(N-1){1'b0}}, 1'b1}
) (
    input  logic         clk,
    input  logic         reset,
    output logic [N-1:0] counter
);

    logic [N-1:0] r_counter;
    logic         w_nonzero;
    logic         w_single;
    logic         w_one_hot;
    logic [N-1:0] w_rotated;
    logic [N-1:0] w_next;

    // One-hot test on the current register value: nonzero, and clearing the
    // lowest set bit (x & (x-1)) leaves nothing behind.
    always_comb begin
        w_nonzero = (r_counter != '0);
        w_single  = ((r_counter & (r_counter - {{(N-1){1'b0}}, 1'b1})) == '0);
        w_one_hot = w_nonzero && w_single;
    end

    // Next state: rotate left with MSB wrapping to bit 0, or recover to INIT.
    always_comb begin
        w_rotated = {r_counter[N-2:0], r_counter[N-1]};
        w_next    = INIT;
        if (w_one_hot) begin
            w_next = w_rotated;
        end
    end

    // State register; reset forces INIT immediately, independent of clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_counter <= INIT;
        end else begin
            r_counter <= w_next;
        end
    end

    // Output comes straight from the flops.
    assign counter = r_counter;

endmodule

// File: tb/tb_ring_counter.sv
// tb_ring_counter: directed checks of the ring counter at N=4 (default), N=2,
// N=8 and N=8 with INIT=8'h10. All four instances share clk and reset.
module tb_ring_counter;

    logic       clk;
    logic       reset;
    logic [1:0] c2;
    logic [3:0] c4;
    logic [7:0] c8;
    logic [7:0] c8i;

    int n_checks;
    int n_err;
    int hits[4];
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    ring_counter #(.N(4)) dut4 (.clk(clk), .reset(reset), .counter(c4));
    ring_counter #(.N(2)) dut2 (.clk(clk), .reset(reset), .counter(c2));
    ring_counter #(.N(8)) dut8 (.clk(clk), .reset(reset), .counter(c8));
    ring_counter #(.N(8), .INIT(8'h10)) dut8i (.clk(clk), .reset(reset), .counter(c8i));

    // Clock and reset: 10 ns period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the edge for sampling.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        reset    = 1'b1;

        // Reset value, before any clock edge.
        #2;
        check("reset_n4",  {4'h0, c4}, 8'h01);
        check("reset_n2",  {6'h0, c2}, 8'h01);
        check("reset_n8",  c8,         8'h01);
        check("reset_n8i", c8i,        8'h10);

        // Release at 10 ns; edges at 15..55 ns.
        #8;
        reset = 1'b0;
        exp_q = '{8'h02, 8'h04, 8'h08, 8'h01, 8'h02};
        for (int i = 0; i < 5; i++) begin
            tick(1);
            exp_v = exp_q.pop_front();
            check("release_n4", {4'h0, c4}, exp_v);
            check("release_n2", {6'h0, c2}, ((i % 2) == 0) ? 8'h02 : 8'h01);
            check("release_n8", c8, 8'h02 << i);
            check("release_n8i", c8i, (i < 3) ? (8'h20 << i) : (8'h01 << (i - 3)));
        end
        // Continue N=8 default to full wrap: after 5 edges at 0x20, need 64,128,1.
        // (checked via one-hot in long run below)

        // Long run: 3 windows of 4 clocks, c4 starts at 0x2.
        for (int k = 0; k < 3; k++) begin
            for (int b = 0; b < 4; b++) hits[b] = 0;
            for (int c = 0; c < 4; c++) begin
                tick(1);
                check("onehot_n4", {7'h0, $onehot(c4)}, 8'h01);
                check("onehot_n8", {7'h0, $onehot(c8)}, 8'h01);
                for (int b = 0; b < 4; b++) if (c4[b]) hits[b]++;
            end
            for (int b = 0; b < 4; b++) check("window_hits", 8'(hits[b]), 8'h01);
            check("period_n4", {4'h0, c4}, 8'h02);
        end

        // Mid-run asynchronous reset. Now at 176 ns, c4 = 2.
        tick(1);
        check("pre_reset_n4", {4'h0, c4}, 8'h04);
        #4;
        reset = 1'b1;
        #1;
        check("async_reset_n4",  {4'h0, c4}, 8'h01);
        check("async_reset_n8i", c8i,        8'h10);
        tick(1);
        check("reset_held_n4", {4'h0, c4}, 8'h01);
        tick(1);
        check("reset_held2_n4", {4'h0, c4}, 8'h01);
        check("reset_held_n8", c8, 8'h01);
        #4;
        reset = 1'b0;
        exp_q = '{8'h02, 8'h04, 8'h08, 8'h01};
        for (int i = 0; i < 4; i++) begin
            tick(1);
            exp_v = exp_q.pop_front();
            check("after_reset_n4", {4'h0, c4}, exp_v);
            check("after_reset_n8i", c8i, (i < 3) ? (8'h20 << i) : 8'h01);
        end

        // Self-correction from all-zeros.
        force dut4.r_counter = 4'b0000;
        #1;
        release dut4.r_counter;
        tick(1);
        check("fix_zero_n4", {4'h0, c4}, 8'h01);
        tick(1);
        check("fix_zero_next_n4", {4'h0, c4}, 8'h02);

        // Self-correction from two bits set (and all-ones on N=8).
        force dut4.r_counter = 4'b0101;
        force dut8.r_counter = 8'hFF;
        #1;
        release dut4.r_counter;
        release dut8.r_counter;
        tick(1);
        check("fix_multi_n4", {4'h0, c4}, 8'h01);
        check("fix_ones_n8",  c8,         8'h01);
        tick(1);
        check("fix_multi_next_n4", {4'h0, c4}, 8'h02);
        check("fix_ones_next_n8",  c8,         8'h02);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
